// File: rtl/ysyx_22040750_exmem_stage.sv
// ysyx_22040750_exmem_stage: EX/MEM pipeline register with store lane alignment and forwarding.
// Define YSYX_22040750_EXMEM_SKID_EN to add a skid entry and register-only O_EX_MEM_ready.
module ysyx_22040750_exmem_stage #(
    parameter int XLEN = 64
) (
    input  logic            I_sys_clk,
    input  logic            I_rst,
    input  logic            I_ex_valid,
    input  logic            I_result_valid,
    input  logic [XLEN-1:0] I_result,
    input  logic [XLEN-1:0] I_csr_wdata,
    input  logic [XLEN-1:0] I_rs2_data,
    input  logic [4:0]      I_rd,
    input  logic            I_reg_wen,
    input  logic            I_mem_ren,
    input  logic            I_mem_wen,
    input  logic            I_csr_wen,
    input  logic [1:0]      I_mem_size,
    input  logic            I_load_sext,
    input  logic [11:0]     I_csr_addr,
    input  logic [XLEN-1:0] I_pc,
    input  logic            I_flush,
    input  logic            I_MEM_ready,
    output logic            O_EX_MEM_ready,
    output logic            O_mem_valid,
    output logic [XLEN-1:0] O_result,
    output logic [XLEN-1:0] O_csr_wdata,
    output logic [4:0]      O_rd,
    output logic            O_reg_wen,
    output logic            O_mem_ren,
    output logic            O_mem_wen,
    output logic            O_csr_wen,
    output logic [1:0]      O_mem_size,
    output logic            O_load_sext,
    output logic [11:0]     O_csr_addr,
    output logic [XLEN-1:0] O_pc,
    output logic [XLEN-1:0] O_wdata,
    output logic [7:0]      O_wmask,
    output logic            O_misalign,
    output logic            O_fwd_valid,
    output logic [4:0]      O_fwd_rd,
    output logic [XLEN-1:0] O_fwd_data
);
    typedef struct packed {
        logic [XLEN-1:0] result;
        logic [XLEN-1:0] csr_wdata;
        logic [XLEN-1:0] rs2;
        logic [XLEN-1:0] pc;
        logic [4:0]      rd;
        logic            reg_wen;
        logic            mem_ren;
        logic            mem_wen;
        logic            csr_wen;
        logic [1:0]      mem_size;
        logic            load_sext;
        logic [11:0]     csr_addr;
    } entry_t;

    entry_t in_e, head_q, head_d;
    logic   head_v_q, head_v_d;
    logic   in_fire, out_fire;
    logic [7:0] base_mask;
    logic [2:0] low_mask;

    assign in_e = '{result: I_result, csr_wdata: I_csr_wdata, rs2: I_rs2_data, pc: I_pc,
                    rd: I_rd, reg_wen: I_reg_wen, mem_ren: I_mem_ren, mem_wen: I_mem_wen,
                    csr_wen: I_csr_wen, mem_size: I_mem_size, load_sext: I_load_sext,
                    csr_addr: I_csr_addr};

    assign in_fire  = I_ex_valid & I_result_valid & O_EX_MEM_ready;
    assign out_fire = head_v_q & I_MEM_ready;

`ifdef YSYX_22040750_EXMEM_SKID_EN
    entry_t skid_q, skid_d;
    logic   skid_v_q, skid_v_d;

    // Ready depends only on the skid register, so the EX side never sees I_MEM_ready.
    assign O_EX_MEM_ready = !skid_v_q;

    always_comb begin
        head_d   = head_q;
        head_v_d = head_v_q;
        skid_d   = skid_q;
        skid_v_d = skid_v_q;
        if (out_fire)
            head_v_d = 1'b0;
        if (out_fire && skid_v_q) begin
            head_d   = skid_q;
            head_v_d = 1'b1;
            skid_v_d = 1'b0;
        end else if (in_fire && (!head_v_q || out_fire)) begin
            head_d   = in_e;
            head_v_d = 1'b1;
        end else if (in_fire) begin
            skid_d   = in_e;
            skid_v_d = 1'b1;
        end
        if (I_flush) begin
            head_v_d = 1'b0;
            skid_v_d = 1'b0;
        end
    end

    always_ff @(posedge I_sys_clk or posedge I_rst) begin
        if (I_rst) begin
            skid_q   <= '0;
            skid_v_q <= 1'b0;
        end else begin
            skid_q   <= skid_d;
            skid_v_q <= skid_v_d;
        end
    end
`else
    assign O_EX_MEM_ready = !head_v_q | I_MEM_ready;

    always_comb begin
        head_d   = head_q;
        head_v_d = head_v_q;
        if (out_fire)
            head_v_d = 1'b0;
        if (in_fire) begin
            head_d   = in_e;
            head_v_d = 1'b1;
        end
        if (I_flush)
            head_v_d = 1'b0;
    end
`endif

    always_ff @(posedge I_sys_clk or posedge I_rst) begin
        if (I_rst) begin
            head_q   <= '0;
            head_v_q <= 1'b0;
        end else begin
            head_q   <= head_d;
            head_v_q <= head_v_d;
        end
    end

    assign O_mem_valid = head_v_q;
    assign O_result    = head_q.result;
    assign O_csr_wdata = head_q.csr_wdata;
    assign O_rd        = head_q.rd;
    assign O_reg_wen   = head_q.reg_wen;
    assign O_mem_ren   = head_q.mem_ren;
    assign O_mem_wen   = head_q.mem_wen;
    assign O_csr_wen   = head_q.csr_wen;
    assign O_mem_size  = head_q.mem_size;
    assign O_load_sext = head_q.load_sext;
    assign O_csr_addr  = head_q.csr_addr;
    assign O_pc        = head_q.pc;

    assign base_mask = head_q.mem_size == 2'd0 ? 8'h01 :
                       head_q.mem_size == 2'd1 ? 8'h03 :
                       head_q.mem_size == 2'd2 ? 8'h0F : 8'hFF;
    // Offset bits that must be zero for a naturally aligned access of this size.
    assign low_mask  = {head_q.mem_size == 2'd3, head_q.mem_size[1], |head_q.mem_size};

    assign O_wdata     = head_q.rs2 << {head_q.result[2:0], 3'b000};
    assign O_wmask     = head_q.mem_wen ? base_mask << head_q.result[2:0] : 8'h00;
    assign O_misalign  = head_v_q & (head_q.mem_ren | head_q.mem_wen) & |(head_q.result[2:0] & low_mask);
    assign O_fwd_valid = head_v_q & head_q.reg_wen & !head_q.mem_ren & |head_q.rd;
    assign O_fwd_rd    = head_q.rd;
    assign O_fwd_data  = head_q.result;
endmodule

// File: tb/tb_ysyx_22040750_exmem_stage.sv
// tb_ysyx_22040750_exmem_stage: directed checks of the EX/MEM stage.
module tb_ysyx_22040750_exmem_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, result_valid, reg_wen, mem_ren, mem_wen, csr_wen, load_sext, flush, mem_ready;
    logic [63:0] result, csr_wdata, rs2, pc;
    logic [4:0]  rd;
    logic [1:0]  mem_size;
    logic [11:0] csr_addr;
    logic        o_ready, o_valid, o_reg_wen, o_mem_ren, o_mem_wen, o_csr_wen, o_sext, o_mis, o_fwd_valid;
    logic [63:0] o_result, o_csr_wdata, o_pc, o_wdata, o_fwd_data;
    logic [4:0]  o_rd, o_fwd_rd;
    logic [1:0]  o_size;
    logic [11:0] o_csr_addr;
    logic [7:0]  o_wmask;
    int checks = 0;
    int errors = 0;

`ifdef YSYX_22040750_EXMEM_SKID_EN
    localparam int EXP_ACC = 2;
`else
    localparam int EXP_ACC = 1;
`endif

    always #5 clk = ~clk;

    ysyx_22040750_exmem_stage #(.XLEN(64)) dut (
        .I_sys_clk(clk), .I_rst(rst),
        .I_ex_valid(ex_valid), .I_result_valid(result_valid), .I_result(result),
        .I_csr_wdata(csr_wdata), .I_rs2_data(rs2), .I_rd(rd),
        .I_reg_wen(reg_wen), .I_mem_ren(mem_ren), .I_mem_wen(mem_wen), .I_csr_wen(csr_wen),
        .I_mem_size(mem_size), .I_load_sext(load_sext), .I_csr_addr(csr_addr), .I_pc(pc),
        .I_flush(flush), .I_MEM_ready(mem_ready), .O_EX_MEM_ready(o_ready),
        .O_mem_valid(o_valid), .O_result(o_result), .O_csr_wdata(o_csr_wdata), .O_rd(o_rd),
        .O_reg_wen(o_reg_wen), .O_mem_ren(o_mem_ren), .O_mem_wen(o_mem_wen), .O_csr_wen(o_csr_wen),
        .O_mem_size(o_size), .O_load_sext(o_sext), .O_csr_addr(o_csr_addr), .O_pc(o_pc),
        .O_wdata(o_wdata), .O_wmask(o_wmask), .O_misalign(o_mis),
        .O_fwd_valid(o_fwd_valid), .O_fwd_rd(o_fwd_rd), .O_fwd_data(o_fwd_data)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [63:0] res, input logic [63:0] d2, input logic [4:0] r,
                         input logic rw, input logic rn, input logic wn, input logic [1:0] sz, input logic sx);
        ex_valid = v; result_valid = 1'b1; result = res; rs2 = d2; rd = r;
        reg_wen = rw; mem_ren = rn; mem_wen = wn; mem_size = sz; load_sext = sx;
        csr_wen = 1'b0; csr_wdata = ~res; csr_addr = 12'h300 ^ {7'h0, r}; pc = res + 64'h1000;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int idx, n_out, seen;
        logic acc;
        logic [4:0] out_rd [3];
        rst = 1'b1; flush = 1'b0; mem_ready = 1'b0;
        drive(1'b0, 64'h0, 64'h0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        #2;
        chk("rst_valid", o_valid, 0);
        chk("rst_ready", o_ready, 1);
        chk("rst_result", o_result, 0);
        chk("rst_wmask", o_wmask, 0);
        cyc(); cyc();
        rst = 1'b0;
        chk("post_rst_ready", o_ready, 1);

        mem_ready = 1'b1;
        drive(1'b1, 64'h8000_0004, 64'h1122_3344, 5'd0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0);
        cyc();
        chk("sw_valid", o_valid, 1);
        chk("sw_wmask", o_wmask, 64'hF0);
        chk("sw_wdata", o_wdata, 64'h1122_3344_0000_0000);
        chk("sw_mis", o_mis, 0);
        chk("sw_csr_wdata", o_csr_wdata, 64'hFFFF_FFFF_7FFF_FFFB);
        chk("sw_pc", o_pc, 64'h8000_1004);
        chk("sw_csr_addr", o_csr_addr, 12'h300);
        chk("sw_fwd", o_fwd_valid, 0);

        drive(1'b1, 64'h8000_0003, 64'h0, 5'd7, 1'b1, 1'b1, 1'b0, 2'd1, 1'b1);
        cyc();
        chk("lh_mis", o_mis, 1);
        chk("lh_fwd", o_fwd_valid, 0);
        chk("lh_wmask", o_wmask, 0);
        chk("lh_sext", o_sext, 1);
        chk("lh_size", o_size, 1);
        chk("lh_rd", o_rd, 7);

        drive(1'b1, 64'h8000_0008, 64'hDEAD_BEEF_0123_4567, 5'd0, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0);
        cyc();
        chk("sd_wmask", o_wmask, 64'hFF);
        chk("sd_wdata", o_wdata, 64'hDEAD_BEEF_0123_4567);
        chk("sd_mis", o_mis, 0);

        drive(1'b1, 64'h8000_000C, 64'h1, 5'd0, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0);
        cyc();
        chk("sd4_mis", o_mis, 1);
        chk("sd4_wmask", o_wmask, 64'hF0);

        drive(1'b1, 64'h8000_0007, 64'hAB, 5'd0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0);
        cyc();
        chk("sb7_wmask", o_wmask, 64'h80);
        chk("sb7_wdata", o_wdata, 64'hAB00_0000_0000_0000);
        chk("sb7_mis", o_mis, 0);

        drive(1'b1, 64'h2A, 64'h0, 5'd5, 1'b1, 1'b0, 1'b0, 2'd3, 1'b0);
        cyc();
        chk("add_fwd", o_fwd_valid, 1);
        chk("add_fwd_rd", o_fwd_rd, 5);
        chk("add_fwd_data", o_fwd_data, 64'h2A);
        chk("add_mis", o_mis, 0);

        drive(1'b1, 64'h2A, 64'h0, 5'd0, 1'b1, 1'b0, 1'b0, 2'd3, 1'b0);
        cyc();
        chk("rd0_fwd", o_fwd_valid, 0);
        chk("rd0_valid", o_valid, 1);

        drive(1'b0, 64'h0, 64'h0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        cyc();
        chk("drain_valid", o_valid, 0);

        drive(1'b1, 64'h77, 64'h0, 5'd3, 1'b1, 1'b0, 1'b0, 2'd3, 1'b0);
        result_valid = 1'b0;
        cyc();
        chk("alu_stall_valid", o_valid, 0);

        mem_ready = 1'b0;
        idx = 0;
        for (int k = 0; k < 3; k++) begin
            drive(idx < 3, 64'h100 * (idx + 1), 64'h0, 5'(idx + 1), 1'b1, 1'b0, 1'b0, 2'd3, 1'b0);
            #1;
            acc = o_ready;
            cyc();
            if (acc) idx++;
        end
        chk("stall_accepted", idx, EXP_ACC);
        chk("stall_ready", o_ready, 0);
        chk("stall_head_rd", o_rd, 1);

        mem_ready = 1'b1;
        n_out = 0;
        for (int k = 0; k < 12 && n_out < 3; k++) begin
            drive(idx < 3, 64'h100 * (idx + 1), 64'h0, 5'(idx + 1), 1'b1, 1'b0, 1'b0, 2'd3, 1'b0);
            #1;
            acc = o_ready & ex_valid;
            if (o_valid) begin
                out_rd[n_out] = o_rd;
                n_out++;
            end
            cyc();
            if (acc) idx++;
        end
        chk("drain_count", n_out, 3);
        chk("drain_0", out_rd[0], 1);
        chk("drain_1", out_rd[1], 2);
        chk("drain_2", out_rd[2], 3);
        drive(1'b0, 64'h0, 64'h0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        chk("drain_no_dup", o_valid, 0);

        mem_ready = 1'b0;
        drive(1'b1, 64'h900, 64'h0, 5'd9, 1'b1, 1'b0, 1'b0, 2'd3, 1'b0);
        cyc();
        chk("flush_held_valid", o_valid, 1);
        chk("flush_held_rd", o_rd, 9);
        drive(1'b1, 64'hA00, 64'h0, 5'd10, 1'b1, 1'b0, 1'b0, 2'd3, 1'b0);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        drive(1'b0, 64'h0, 64'h0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        chk("flush_valid", o_valid, 0);
        chk("flush_ready", o_ready, 1);
        mem_ready = 1'b1;
        seen = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            if (o_valid) seen++;
            cyc();
        end
        chk("flush_no_emit", seen, 0);

        mem_ready = 1'b0;
        drive(1'b1, 64'h8000_0010, 64'h55, 5'd11, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0);
        cyc();
        chk("rst_mid_valid", o_valid, 1);
        chk("rst_mid_wmask", o_wmask, 64'h0F);
        drive(1'b1, 64'hC00, 64'h0, 5'd12, 1'b1, 1'b0, 1'b0, 2'd3, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", o_valid, 0);
        chk("arst_result", o_result, 0);
        chk("arst_rd", o_rd, 0);
        chk("arst_wmask", o_wmask, 0);
        chk("arst_wdata", o_wdata, 0);
        chk("arst_pc", o_pc, 0);
        chk("arst_ready", o_ready, 1);
        drive(1'b0, 64'h0, 64'h0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        cyc(); cyc();
        rst = 1'b0;
        chk("rel_ready", o_ready, 1);
        chk("rel_valid", o_valid, 0);
        cyc();
        chk("rel_ready_next", o_ready, 1);
        mem_ready = 1'b1;
        seen = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            if (o_valid) seen++;
            cyc();
        end
        chk("rel_no_emit", seen, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ysyx_22040750_exmem_stage.md
YSYX_22040750_EXMEM_STAGE -- requirements
Module: ysyx_22040750_exmem_stage

Interface
REQ-001 SHALL have parameter: XLEN, 64, datapath width; only value supported is 64.
REQ-002 SHALL have port: I_sys_clk  in  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port: I_rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have inputs from the EX stage:
- I_ex_valid  1  EX holds an instruction.
- I_result_valid  1  ALU result is final.
- I_result  64  ALU result, which is also the memory address for loads and stores.
- I_csr_wdata  64  CSR write value.
- I_rs2_data  64  store source data.
- I_rd  5  destination register.
- I_reg_wen, I_mem_ren, I_mem_wen, I_csr_wen  1 each  control bits.
- I_mem_size  2  access size: 0=B, 1=H, 2=W, 3=D.
- I_load_sext  1  sign-extend the load.
- I_csr_addr  12  CSR address.
- I_pc  64  instruction PC.
REQ-005 SHALL have port: I_flush  in  1  kill all held entries.
REQ-006 SHALL have port: I_MEM_ready  in  1  MEM stage accepts the head entry.
REQ-007 SHALL have port: O_EX_MEM_ready  out  1  stage can accept an entry; drives the ALU input of the same name.
REQ-008 SHALL have output port: O_mem_valid  1  head entry valid.
REQ-009 SHALL have registered outputs O_result, O_csr_wdata, O_rd, O_reg_wen, O_mem_ren, O_mem_wen, O_csr_wen, O_mem_size, O_load_sext, O_csr_addr, O_pc, with widths equal to their inputs.
REQ-010 SHALL have output port: O_wdata  64  store data aligned to the byte lane.
REQ-011 SHALL have output port: O_wmask  8  byte-write strobe.
REQ-012 SHALL have output port: O_misalign  1  the memory access is not naturally aligned.
REQ-013 SHALL have forwarding output ports: O_fwd_valid  1, O_fwd_rd  5, O_fwd_data  64.

Function
REQ-014 SHALL define in_fire = I_ex_valid & I_result_valid & O_EX_MEM_ready.
REQ-015 SHALL define out_fire = O_mem_valid & I_MEM_ready.
REQ-016 SHALL capture every REQ-004 field into the head register on in_fire when the head is empty or out_fire is true in the same cycle; latency is 1 cycle.
REQ-017 SHALL clear O_mem_valid on out_fire without a refill; SHALL hold the head unchanged while O_mem_valid & !I_MEM_ready.
REQ-018 SHALL compute O_wdata = O-side rs2 << (8*O_result[2:0]).
REQ-019 SHALL compute O_wmask = {1,3,F,FF}[O_mem_size] << O_result[2:0], truncated to 8 bits; O_wmask SHALL be 0 when O_mem_wen=0.
REQ-020 SHALL assert O_misalign = O_mem_valid & (O_mem_ren|O_mem_wen) & (O_result[2:0] & ((1<<O_mem_size)-1)) != 0; O_wmask is still produced, truncated, while O_misalign is asserted.
REQ-021 SHALL assert O_fwd_valid = O_mem_valid & O_reg_wen & !O_mem_ren & (O_rd!=0).
REQ-022 SHALL drive O_fwd_rd = O_rd and O_fwd_data = O_result.
REQ-023 SHALL, on I_flush, clear all valid bits at the next edge; flush SHALL take priority over in_fire and out_fire in the same cycle, and data registers MAY keep stale values.
REQ-024 SHALL ignore I_result_valid=0 with I_ex_valid=1, treating it as a multicycle ALU stall: no capture and no bubble counted.
REQ-025 SHALL never duplicate or drop an entry under any mix of I_MEM_ready and in_fire.

Reset
REQ-026 SHALL, while I_rst=1, force O_mem_valid=0, skid valid=0 and every registered output to 0, independent of the clock.
REQ-027 SHALL drive O_EX_MEM_ready=1 during reset and in the first cycle after it.
REQ-028 SHALL discard any in-flight entry when reset is asserted mid-transfer, with nothing emitted after release.

Configuration
REQ-029 SHALL use macro YSYX_22040750_EXMEM_SKID_EN.
REQ-030 SHALL, when the macro is undefined, drive O_EX_MEM_ready = !O_mem_valid | I_MEM_ready, combinational from I_MEM_ready, giving a single entry.
REQ-031 SHALL, when the macro is defined, add one skid entry and drive O_EX_MEM_ready = !skid_valid from a register only, with no combinational path from I_MEM_ready.
REQ-032 SHALL, with the skid entry, write in_fire into the skid when the head is held; on out_fire the skid moves to the head and the skid is cleared in the same edge; entries SHALL leave in FIFO order.

Verification
REQ-033 SHALL cover: sw, result=0x8000_0004, rs2=0x1122_3344, size=2, MEM ready -> next cycle O_wmask=0xF0, O_wdata=0x1122_3344_0000_0000, O_misalign=0.
REQ-034 SHALL cover: lh, result=0x8000_0003 -> O_misalign=1 and O_fwd_valid=0.
REQ-035 SHALL cover: add rd=5, result=0x2A -> O_fwd_valid=1, O_fwd_rd=5, O_fwd_data=0x2A; rd=0 -> O_fwd_valid=0.
REQ-036 SHALL cover: I_MEM_ready low for 3 cycles with 3 back-to-back inputs -> no-skid build accepts 1 entry; SKID_EN build accepts 2, drops O_EX_MEM_ready, then drains in order.
REQ-037 SHALL cover: I_flush together with in_fire and a held head -> O_mem_valid=0 next cycle and no entry emitted later.
REQ-038 SHALL cover: I_rst pulsed mid-stall -> all outputs 0 asynchronously and O_EX_MEM_ready=1 after release.
